sprite_info_pingpong: RTL and testbench
=======================================

Name: sprite_info_pingpong

Overview:
- Double-buffered sprite-attribute store that sits between the SPI command decoder (writer) and the sprite renderer (reader).
- Generalises the single shared sprite-info BRAM into two banks: a shadow bank the command side fills and an active bank the renderer reads.
- Banks swap atomically on a frame-commit handshake, so the renderer never sees a half-written sprite list.
- Owns the RenderNextFrame / FinishedRendering handshake and the latched NumSprites.

Parameters:
- MAX_SPRITES, 4096, sprite entries per bank (power of two).
- ADDR_W, 12, sprite index width; log2(MAX_SPRITES).
- DATA_W, 30, bits per sprite-info entry.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).

Ports:
- Clk, input, 1, sole clock.
- Rst, input, 1, asynchronous active-high reset.
- WrEn, input, 1, write strobe (command side).
- WrAddr, input, ADDR_W, sprite index in the shadow bank.
- WrData, input, DATA_W, sprite-info word.
- WrReady, output, 1, high when writes are accepted.
- CommitReq, input, 1, one-cycle pulse: shadow frame complete.
- NumSpritesIn, input, ADDR_W+1, sprite count of the committed frame.
- CommitBusy, output, 1, high while a committed frame awaits swap.
- RdEn, input, 1, read strobe (renderer).
- RdAddr, input, ADDR_W, sprite index in the active bank.
- RdData, output, DATA_W, read data.
- RdValid, output, 1, RdData valid.
- RenderNextFrame, output, 1, one-cycle pulse: new frame active.
- FinishedRendering, input, 1, one-cycle pulse from renderer.
- NumSprites, output, ADDR_W+1, sprite count of the active frame.
- FrameCount, output, 16, number of swaps; wraps at 65535 -> 0.
- CommitOverrun, output, 1, sticky: CommitReq while CommitBusy.
- WrDropped, output, 1, sticky: WrEn while WrReady low.

Behaviour:
- Storage: 2*MAX_SPRITES x DATA_W RAM with no reset on contents. RdBank register; the write bank is always ~RdBank.
- Reset values: state IDLE, RdBank=0, WrReady=1, CommitBusy=0, RdData=0, RdValid=0, RenderNextFrame=0, NumSprites=0, FrameCount=0, CommitOverrun=0, WrDropped=0.
- Reset mid-operation aborts any pending swap. RAM contents persist but carry no guarantee.
- Write: when WrEn && WrReady, write WrData to bank ~RdBank at WrAddr on the same edge. When WrEn && !WrReady, drop the write and set WrDropped.
- Read: RdEn sampled at edge N reads bank RdBank as it is before edge N. RdData/RdValid appear after RD_LATENCY edges. RdValid is the RdEn delay line; RdData holds its value when RdValid=0.
- Swap action (one edge):
  - toggle RdBank;
  - NumSprites <= min(NumSpritesIn latched at commit, MAX_SPRITES);
  - FrameCount += 1;
  - RenderNextFrame=1 for exactly the following cycle.
- State machine:
  - IDLE: CommitReq -> swap, go RENDERING.
  - RENDERING:
    - CommitReq and not FinishedRendering -> latch NumSpritesIn, WrReady=0, CommitBusy=1, go PENDING.
    - FinishedRendering only -> IDLE.
    - Both on the same edge -> swap immediately, stay RENDERING.
  - PENDING:
    - FinishedRendering -> swap, WrReady=1, CommitBusy=0, go RENDERING.
    - CommitReq (with or without FinishedRendering) -> set CommitOverrun and ignore the new NumSpritesIn. Any FinishedRendering on that edge is still honoured.
  - FinishedRendering in IDLE is ignored.
- Commit latency: CommitReq at edge N in IDLE -> RenderNextFrame high in cycle N+1, new NumSprites visible in cycle N+1, and reads sampled from edge N+1 hit the new bank.
- A write and CommitReq on the same edge: the write lands in the committed frame.
- Sticky flags clear only on Rst.

Test Plan:
- Reset, write entries 0..3 = 0x1..0x4, CommitReq with NumSpritesIn=4 -> RenderNextFrame pulse 1 cycle later, NumSprites=4, FrameCount=1; reads of 0..3 return 0x1..0x4 with RdValid after RD_LATENCY.
- While rendering frame A, write entry 0=0xAA and commit -> CommitBusy=1, WrReady=0; reads still return frame A. FinishedRendering -> swap, entry 0 reads 0xAA, CommitBusy=0.
- In PENDING, pulse WrEn and a second CommitReq -> WrDropped=1, CommitOverrun=1; shadow data and NumSprites unchanged after the swap.
- CommitReq and FinishedRendering on the same edge in RENDERING -> immediate swap, RenderNextFrame pulse, state stays RENDERING; NumSpritesIn=5000 with MAX_SPRITES=4096 -> NumSprites=4096.
- Assert Rst asynchronously mid-PENDING -> all outputs return to reset values immediately; the next commit swaps to bank 1 with FrameCount=1.
- Perform 65536 swaps -> FrameCount wraps to 0; repeat the first scenario with RD_LATENCY=2 -> data is 2 cycles after RdEn.

Source files
------------

// File: rtl/sprite_info_pingpong.sv
// Double-buffered sprite-attribute store: the command side fills the shadow bank,
// the renderer reads the active bank, and the banks swap on a frame-commit handshake.
module sprite_info_pingpong #(
    parameter int MAX_SPRITES = 4096,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 30,
    parameter int RD_LATENCY  = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic              WrReady,
    input  logic              CommitReq,
    input  logic [ADDR_W:0]   NumSpritesIn,
    output logic              CommitBusy,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [DATA_W-1:0] RdData,
    output logic              RdValid,
    output logic              RenderNextFrame,
    input  logic              FinishedRendering,
    output logic [ADDR_W:0]   NumSprites,
    output logic [15:0]       FrameCount,
    output logic              CommitOverrun,
    output logic              WrDropped
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RENDERING = 2'd1,
        PENDING   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_SPRITES);

    state_t            state_r;
    logic              rd_bank_r;
    logic [ADDR_W:0]   num_latched_r;
    logic [DATA_W-1:0] mem [0:2*MAX_SPRITES-1];

    logic              wr_fire_s;
    logic [ADDR_W:0]   wr_idx_s;
    logic [ADDR_W:0]   rd_idx_s;
    logic              do_swap_s;
    logic [ADDR_W:0]   swap_cnt_s;

    function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] n);
        if (n > MAX_CNT) begin
            return MAX_CNT;
        end else begin
            return n;
        end
    endfunction

    assign wr_fire_s = WrEn && WrReady;
    assign wr_idx_s  = {~rd_bank_r, WrAddr};
    assign rd_idx_s  = {rd_bank_r, RdAddr};

    // Decide whether this edge swaps banks and which sprite count the new frame takes.
    always_comb begin
        do_swap_s  = 1'b0;
        swap_cnt_s = NumSpritesIn;
        case (state_r)
            IDLE:      do_swap_s = CommitReq;
            RENDERING: do_swap_s = CommitReq && FinishedRendering;
            PENDING: begin
                do_swap_s  = FinishedRendering;
                swap_cnt_s = num_latched_r;
            end
            default:   do_swap_s = 1'b0;
        endcase
    end

    // Commit/render handshake FSM with bank pointer, counters and sticky flags.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r         <= IDLE;
            rd_bank_r       <= 1'b0;
            num_latched_r   <= '0;
            WrReady         <= 1'b1;
            CommitBusy      <= 1'b0;
            RenderNextFrame <= 1'b0;
            NumSprites      <= '0;
            FrameCount      <= 16'd0;
            CommitOverrun   <= 1'b0;
            WrDropped       <= 1'b0;
        end else begin
            RenderNextFrame <= do_swap_s;
            if (do_swap_s) begin
                rd_bank_r  <= ~rd_bank_r;
                NumSprites <= clamp_count(swap_cnt_s);
                FrameCount <= FrameCount + 16'd1;
            end
            if (WrEn && !WrReady) begin
                WrDropped <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (CommitReq) begin
                        state_r <= RENDERING;
                    end
                end
                RENDERING: begin
                    if (CommitReq && !FinishedRendering) begin
                        num_latched_r <= NumSpritesIn;
                        WrReady       <= 1'b0;
                        CommitBusy    <= 1'b1;
                        state_r       <= PENDING;
                    end else if (FinishedRendering && !CommitReq) begin
                        state_r <= IDLE;
                    end
                end
                PENDING: begin
                    // A second commit cannot be queued; flag it and keep the first count.
                    if (CommitReq) begin
                        CommitOverrun <= 1'b1;
                    end
                    if (FinishedRendering) begin
                        WrReady    <= 1'b1;
                        CommitBusy <= 1'b0;
                        state_r    <= RENDERING;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Shadow-bank write port; RAM contents are never reset.
    always_ff @(posedge Clk) begin
        if (wr_fire_s) begin
            mem[wr_idx_s] <= WrData;
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_rd1
            // Single-cycle read: RdData only updates on a read so it holds otherwise.
            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    RdData  <= '0;
                    RdValid <= 1'b0;
                end else begin
                    RdValid <= RdEn;
                    if (RdEn) begin
                        RdData <= mem[rd_idx_s];
                    end
                end
            end
        end else begin : g_rd2
            logic [DATA_W-1:0] ram_q_r;
            logic              valid1_r;

            // RAM output register stage.
            always_ff @(posedge Clk) begin
                if (RdEn) begin
                    ram_q_r <= mem[rd_idx_s];
                end
            end

            // Extra output register for the two-cycle read path.
            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    valid1_r <= 1'b0;
                    RdData   <= '0;
                    RdValid  <= 1'b0;
                end else begin
                    valid1_r <= RdEn;
                    RdValid  <= valid1_r;
                    if (valid1_r) begin
                        RdData <= ram_q_r;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_sprite_info_pingpong.sv
// Directed bench for sprite_info_pingpong; two instances (read latency 1 and 2) share stimulus.
module tb_sprite_info_pingpong;
    logic        Clk;
    logic        Rst;
    logic        WrEn;
    logic [11:0] WrAddr;
    logic [29:0] WrData;
    logic        CommitReq;
    logic [12:0] NumSpritesIn;
    logic        RdEn;
    logic [11:0] RdAddr;
    logic        FinishedRendering;

    logic        wr_ready_a, commit_busy_a, rd_valid_a, rnf_a, overrun_a, dropped_a;
    logic [29:0] rd_data_a;
    logic [12:0] num_sprites_a;
    logic [15:0] frame_count_a;
    logic        wr_ready_b, commit_busy_b, rd_valid_b, rnf_b, overrun_b, dropped_b;
    logic [29:0] rd_data_b;
    logic [12:0] num_sprites_b;
    logic [15:0] frame_count_b;

    typedef struct {
        logic [29:0] data;
        int          due;
    } rd_t;

    rd_t q1[$];
    rd_t q2[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    sprite_info_pingpong #(.RD_LATENCY(1)) dut_a (
        .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .WrReady(wr_ready_a), .CommitReq(CommitReq), .NumSpritesIn(NumSpritesIn),
        .CommitBusy(commit_busy_a), .RdEn(RdEn), .RdAddr(RdAddr), .RdData(rd_data_a),
        .RdValid(rd_valid_a), .RenderNextFrame(rnf_a), .FinishedRendering(FinishedRendering),
        .NumSprites(num_sprites_a), .FrameCount(frame_count_a),
        .CommitOverrun(overrun_a), .WrDropped(dropped_a)
    );

    sprite_info_pingpong #(.RD_LATENCY(2)) dut_b (
        .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .WrReady(wr_ready_b), .CommitReq(CommitReq), .NumSpritesIn(NumSpritesIn),
        .CommitBusy(commit_busy_b), .RdEn(RdEn), .RdAddr(RdAddr), .RdData(rd_data_b),
        .RdValid(rd_valid_b), .RenderNextFrame(rnf_b), .FinishedRendering(FinishedRendering),
        .NumSprites(num_sprites_b), .FrameCount(frame_count_b),
        .CommitOverrun(overrun_b), .WrDropped(dropped_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [29:0] d);
        WrEn = 1'b1; WrAddr = a; WrData = d;
        tick();
        WrEn = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [29:0] e);
        RdEn = 1'b1; RdAddr = a;
        q1.push_back('{e, cyc + 1});
        q2.push_back('{e, cyc + 2});
        tick();
        RdEn = 1'b0;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wrready"},  {31'd0, wr_ready_a}, 32'd1);
        chk({tag, "_busy"},     {31'd0, commit_busy_a}, 32'd0);
        chk({tag, "_rdvalid"},  {31'd0, rd_valid_a}, 32'd0);
        chk({tag, "_rddata"},   {2'd0, rd_data_a}, 32'd0);
        chk({tag, "_rnf"},      {31'd0, rnf_a}, 32'd0);
        chk({tag, "_nspr"},     {19'd0, num_sprites_a}, 32'd0);
        chk({tag, "_fc"},       {16'd0, frame_count_a}, 32'd0);
        chk({tag, "_overrun"},  {31'd0, overrun_a}, 32'd0);
        chk({tag, "_dropped"},  {31'd0, dropped_a}, 32'd0);
        chk({tag, "_b_rddata"}, {2'd0, rd_data_b}, 32'd0);
        chk({tag, "_b_fc"},     {16'd0, frame_count_b}, 32'd0);
    endtask

    // Read-data scoreboards: pop on RdValid and check data plus arrival cycle.
    always @(negedge Clk) begin
        rd_t e;
        if (q1.size() > 0 && q1[0].due < cyc) begin
            e = q1.pop_front();
            chk("rd1_missing", 32'd0, 32'd1);
        end
        if (rd_valid_a) begin
            if (q1.size() == 0) begin
                chk("rd1_unexpected", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("rd1_data", {2'd0, rd_data_a}, {2'd0, e.data});
                chk("rd1_cycle", cyc, e.due);
            end
        end
    end

    always @(negedge Clk) begin
        rd_t e;
        if (q2.size() > 0 && q2[0].due < cyc) begin
            e = q2.pop_front();
            chk("rd2_missing", 32'd0, 32'd1);
        end
        if (rd_valid_b) begin
            if (q2.size() == 0) begin
                chk("rd2_unexpected", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                chk("rd2_data", {2'd0, rd_data_b}, {2'd0, e.data});
                chk("rd2_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        Rst = 1'b1; WrEn = 1'b0; WrAddr = 12'd0; WrData = 30'd0; CommitReq = 1'b0;
        NumSpritesIn = 13'd0; RdEn = 1'b0; RdAddr = 12'd0; FinishedRendering = 1'b0;
        tick();
        tick();
        chk_reset("reset");
        Rst = 1'b0;
        tick();

        // Frame A: entries 0..3 = 1..4, commit from IDLE.
        for (int i = 0; i < 4; i++) wr(12'(i), 30'(i + 1));
        CommitReq = 1'b1; NumSpritesIn = 13'd4;
        tick();
        CommitReq = 1'b0;
        chk("c1_rnf", {31'd0, rnf_a}, 32'd1);
        chk("c1_nspr", {19'd0, num_sprites_a}, 32'd4);
        chk("c1_fc", {16'd0, frame_count_a}, 32'd1);
        chk("c1_b_nspr", {19'd0, num_sprites_b}, 32'd4);
        for (int i = 0; i < 4; i++) rd(12'(i), 30'(i + 1));
        chk("c1_rnf_pulse", {31'd0, rnf_a}, 32'd0);
        drain();

        // Fill shadow and commit while rendering: swap must wait.
        wr(12'd0, 30'h0AA);
        wr(12'd1, 30'h022);
        CommitReq = 1'b1; NumSpritesIn = 13'd3;
        tick();
        CommitReq = 1'b0;
        chk("pend_busy", {31'd0, commit_busy_a}, 32'd1);
        chk("pend_wrready", {31'd0, wr_ready_a}, 32'd0);
        chk("pend_rnf", {31'd0, rnf_a}, 32'd0);
        chk("pend_fc", {16'd0, frame_count_a}, 32'd1);
        rd(12'd0, 30'h1);
        drain();

        // Dropped write and overrun commit while pending.
        WrEn = 1'b1; WrAddr = 12'd1; WrData = 30'h055;
        CommitReq = 1'b1; NumSpritesIn = 13'd7;
        tick();
        WrEn = 1'b0; CommitReq = 1'b0;
        chk("ovr_dropped", {31'd0, dropped_a}, 32'd1);
        chk("ovr_overrun", {31'd0, overrun_a}, 32'd1);
        chk("ovr_busy", {31'd0, commit_busy_a}, 32'd1);
        chk("ovr_nspr", {19'd0, num_sprites_a}, 32'd4);
        FinishedRendering = 1'b1;
        tick();
        FinishedRendering = 1'b0;
        chk("sw2_rnf", {31'd0, rnf_a}, 32'd1);
        chk("sw2_nspr", {19'd0, num_sprites_a}, 32'd3);
        chk("sw2_fc", {16'd0, frame_count_a}, 32'd2);
        chk("sw2_busy", {31'd0, commit_busy_a}, 32'd0);
        chk("sw2_wrready", {31'd0, wr_ready_a}, 32'd1);
        chk("sw2_sticky", {30'd0, overrun_a, dropped_a}, 32'd3);
        rd(12'd0, 30'h0AA);
        rd(12'd1, 30'h022);
        drain();

        // Commit and finish on the same edge: immediate swap with clamped count.
        CommitReq = 1'b1; FinishedRendering = 1'b1; NumSpritesIn = 13'd5000;
        tick();
        CommitReq = 1'b0; FinishedRendering = 1'b0;
        chk("both_rnf", {31'd0, rnf_a}, 32'd1);
        chk("both_nspr", {19'd0, num_sprites_a}, 32'd4096);
        chk("both_fc", {16'd0, frame_count_a}, 32'd3);
        chk("both_busy", {31'd0, commit_busy_a}, 32'd0);
        rd(12'd2, 30'h3);
        drain();
        CommitReq = 1'b1; NumSpritesIn = 13'd9;
        tick();
        CommitReq = 1'b0;
        chk("stay_rend_busy", {31'd0, commit_busy_a}, 32'd1);
        chk("stay_rend_fc", {16'd0, frame_count_a}, 32'd3);

        // Asynchronous reset while pending.
        Rst = 1'b1;
        #1;
        chk_reset("async_rst");
        Rst = 1'b0;
        tick();
        wr(12'd0, 30'h077);
        CommitReq = 1'b1; NumSpritesIn = 13'd2;
        tick();
        CommitReq = 1'b0;
        chk("post_rst_fc", {16'd0, frame_count_a}, 32'd1);
        chk("post_rst_nspr", {19'd0, num_sprites_a}, 32'd2);
        rd(12'd0, 30'h077);
        drain();

        // Back-to-back swaps until the frame counter wraps.
        CommitReq = 1'b1; FinishedRendering = 1'b1; NumSpritesIn = 13'd1;
        for (int i = 0; i < 65534; i++) tick();
        chk("wrap_max", {16'd0, frame_count_a}, 32'd65535);
        tick();
        CommitReq = 1'b0; FinishedRendering = 1'b0;
        chk("wrap_zero", {16'd0, frame_count_a}, 32'd0);
        chk("wrap_b_zero", {16'd0, frame_count_b}, 32'd0);
        chk("wrap_nspr", {19'd0, num_sprites_a}, 32'd1);
        drain();

        chk("q1_empty", q1.size(), 32'd0);
        chk("q2_empty", q2.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
